// File: rtl/mul_share_pkg.sv
// ----------------------------------------------------------------------------
// mul_share_pkg
// Shared definitions for the shared-multiplier arbiter slice.
//   idw_of   : width of a requester index for a given requester count.
//   rr_pick  : round-robin scan of a request vector starting at a pointer,
//              returning whether anything was found and the winning index.
// ----------------------------------------------------------------------------
package mul_share_pkg;

    // Upper bound on the requester count the helper function can scan.
    localparam int RR_MAX_REQ = 64;
    localparam int RR_IDX_W   = 6;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Scan valid[ptr], valid[ptr+1], ... wrapping at nreq-1 back to 0 and
    // return the first set position. Only the first nreq bits are considered.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                         input int nreq,
                                         input int ptr);
        rr_pick_t            res;
        int                  k;
        logic [RR_IDX_W-1:0] k_idx;
        res = '0;
        for (int o = 0; o < RR_MAX_REQ; o++) begin
            if (o < nreq) begin
                k = ptr + o;
                if (k >= nreq) begin
                    k = k - nreq;
                end
                k_idx = k[RR_IDX_W-1:0];
                if (!res.found && valid[k_idx]) begin
                    res.found = 1'b1;
                    res.idx   = k_idx;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ArrayMultiplier.sv
// ----------------------------------------------------------------------------
// ArrayMultiplier
// Purely combinational unsigned m x n multiplier built as a row-per-bit
// accumulation of shifted partial products.
//   a : multiplicand, m bits
//   x : multiplier,   n bits
//   p : full product, m+n bits (no truncation)
// ----------------------------------------------------------------------------
module ArrayMultiplier #(
    parameter int m = 32,
    parameter int n = 32
) (
    input  logic [m-1:0]   a,
    input  logic [n-1:0]   x,
    output logic [m+n-1:0] p
);

    // Each set bit of x contributes a copy of a shifted into its row.
    always_comb begin
        p = '0;
        for (int i = 0; i < n; i++) begin
            if (x[i]) begin
                p = p + ((m+n)'(a) << i);
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The pointer register lives in the
// instantiating module; this block only decides who wins this cycle.
//   req       : per-requester request
//   ptr       : requester with highest priority this cycle
//   enable    : when low, nobody is granted
//   grant     : one-hot grant (or zero)
//   grant_idx : index of the granted requester (0 when none)
//   any_grant : a grant was issued
// ----------------------------------------------------------------------------
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = idw_of(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_grant
);

    logic [RR_MAX_REQ-1:0] req_ext;
    rr_pick_t              pick;

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        pick                = rr_pick(req_ext, NREQ, int'(ptr));
        grant               = '0;
        grant_idx           = '0;
        any_grant           = 1'b0;
        if (enable && pick.found) begin
            any_grant        = 1'b1;
            grant_idx        = IDW'(pick.idx);
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// ----------------------------------------------------------------------------
// mul_share_arbiter
// Shares one combinational ArrayMultiplier among NREQ requesters. A
// round-robin arbiter loads the operand stage S1; the multiplier sits between
// S1 and the result stage S2, which drives the single response channel.
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   req_valid   : per-requester request valid
//   req_ready   : per-requester grant, one-hot or zero
//   req_a/req_x : packed operands, requester i at [i*M +: M] / [i*N +: N]
//   rsp_valid   : result valid
//   rsp_ready   : consumer accepts result
//   rsp_id      : requester that issued the result
//   rsp_product : unsigned a*x, M+N bits
//   busy        : an operation is held in S1 or S2
// ----------------------------------------------------------------------------
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter  int M    = 32,
    parameter  int N    = 32,
    parameter  int NREQ = 4,
    localparam int IDW  = idw_of(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*M-1:0] req_a,
    input  logic [NREQ*N-1:0] req_x,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [M+N-1:0]    rsp_product,
    output logic              busy
);

    logic             s1_valid;
    logic [M-1:0]     s1_a;
    logic [N-1:0]     s1_x;
    logic [IDW-1:0]   s1_id;
    logic             s2_valid;
    logic [M+N-1:0]   s2_product;
    logic [IDW-1:0]   s2_id;
    logic [IDW-1:0]   rr_ptr;

    logic             s2_free;
    logic             s1_adv;
    logic             s1_free;
    logic             rsp_fire;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             any_grant;
    logic [M-1:0]     sel_a;
    logic [N-1:0]     sel_x;
    logic [M+N-1:0]   mul_p;

    assign rsp_fire = s2_valid && rsp_ready;
    assign s2_free  = !s2_valid || rsp_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign s1_free  = !s1_valid || s2_free;

    // Gating with rst keeps req_ready low while reset is held, since the
    // cleared pipeline would otherwise look free.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .enable    (s1_free && !rst),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign req_ready = grant;
    assign sel_a     = req_a[grant_idx*M +: M];
    assign sel_x     = req_x[grant_idx*N +: N];

    ArrayMultiplier #(.m(M), .n(N)) u_mul (
        .a (s1_a),
        .x (s1_x),
        .p (mul_p)
    );

    // Priority moves to the requester just after the one that won.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // S1: a fire refills the stage even when it advances the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_x     <= '0;
            s1_id    <= '0;
        end else if (any_grant) begin
            s1_valid <= 1'b1;
            s1_a     <= sel_a;
            s1_x     <= sel_x;
            s1_id    <= grant_idx;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: loading wins over draining, so a simultaneous drain and load keeps
    // the stage valid with the new result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_product <= '0;
            s2_id      <= '0;
        end else if (s1_adv) begin
            s2_valid   <= 1'b1;
            s2_product <= mul_p;
            s2_id      <= s1_id;
        end else if (rsp_fire) begin
            s2_valid   <= 1'b0;
        end
    end

    assign rsp_valid   = s2_valid;
    assign rsp_id      = s2_id;
    assign rsp_product = s2_product;
    assign busy        = s1_valid || s2_valid;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mul_share_arbiter
// Self-checking bench for mul_share_arbiter. The reference model treats the
// unit as a two-deep in-order queue: it accepts a request when it holds fewer
// than two operations or the consumer is taking one, picks the winner by a
// plain round-robin scan, and expects each product to appear two edges after
// its request fired, oldest first.
// ----------------------------------------------------------------------------
module tb_mul_share_arbiter;

    localparam int M    = 32;
    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int PW   = M + N;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*M-1:0] req_a;
    logic [NREQ*N-1:0] req_x;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [PW-1:0]     rsp_product;
    logic              busy;

    mul_share_arbiter #(.M(M), .N(N), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_x       (req_x),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            id;
        logic [PW-1:0] prod;
        int            age;
    } exp_t;

    exp_t            sb[$];
    int              model_ptr  = 0;
    bit              model_on   = 1'b0;
    logic [NREQ-1:0] fired_mask = '0;

    task automatic checkOutput(input string name, input logic [PW-1:0] actual,
                               input logic [PW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    function automatic logic [PW-1:0] refProduct(input logic [M-1:0] a,
                                                 input logic [N-1:0] x);
        return PW'(a) * PW'(x);
    endfunction

    function automatic logic [M-1:0] randA();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return M'($urandom());
        endcase
    endfunction

    function automatic logic [N-1:0] randX();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return N'($urandom());
        endcase
    endfunction

    // Monitor and scoreboard: runs between edges and predicts the next edge.
    logic            exp_rv;
    logic            rfire;
    logic            room;
    int              g;
    int              k;
    logic [NREQ-1:0] exp_grant;
    exp_t            e;

    always @(negedge clk) begin
        if (model_on && !rst) begin
            checkOutput("busy", PW'(busy), PW'(sb.size() > 0));
            exp_rv = (sb.size() > 0) && (sb[0].age >= 2);
            checkOutput("rsp_valid", PW'(rsp_valid), PW'(exp_rv));
            if (exp_rv && rsp_valid) begin
                checkOutput("rsp_id", PW'(rsp_id), PW'(unsigned'(sb[0].id)));
                checkOutput("rsp_product", rsp_product, sb[0].prod);
            end
            rfire = exp_rv && rsp_ready;
            room  = (sb.size() < 2) || rsp_ready;
            g     = -1;
            if (room) begin
                for (int o = 0; o < NREQ; o++) begin
                    k = (model_ptr + o) % NREQ;
                    if (g < 0 && req_valid[k]) g = k;
                end
            end
            exp_grant = '0;
            if (g >= 0) exp_grant[g] = 1'b1;
            checkOutput("req_ready", PW'(req_ready), PW'(exp_grant));
            fired_mask = req_valid & req_ready;
            if (rfire) void'(sb.pop_front());
            if (g >= 0) begin
                e.id   = g;
                e.prod = refProduct(req_a[g*M +: M], req_x[g*N +: N]);
                e.age  = 0;
                sb.push_back(e);
                model_ptr = (g + 1) % NREQ;
            end
            foreach (sb[i]) sb[i].age++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic v, input logic [M-1:0] a,
                          input logic [N-1:0] x);
        req_valid[i]     = v;
        req_a[i*M +: M]  = a;
        req_x[i*N +: N]  = x;
    endtask

    // Requesters hold an unfired request; otherwise they may raise a new one.
    task automatic applyStimulus(input int cycles, input int valid_pct,
                                 input int ready_pct, input logic [NREQ-1:0] allowed);
        repeat (cycles) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !fired_mask[i])) begin
                    setReq(i, allowed[i] && ($urandom_range(0, 99) < valid_pct),
                           randA(), randX());
                end
            end
            rsp_ready = ($urandom_range(0, 99) < ready_pct);
            tick();
        end
    endtask

    task automatic doReset();
        model_on = 1'b0;
        rst      = 1'b1;
        tick();
        rst        = 1'b0;
        sb.delete();
        model_ptr  = 0;
        fired_mask = '0;
        model_on   = 1'b1;
    endtask

    task automatic drainPipe();
        for (int c = 0; c < 40 && (sb.size() > 0 || req_valid != '0); c++) begin
            applyStimulus(1, 0, 100, '1);
        end
        checkOutput("drain_empty", PW'(sb.size()), '0);
        checkOutput("drain_busy", PW'(busy), '0);
    endtask

    int w;

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_x     = '0;
        rsp_ready = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with every requester asking to show no grant leaks out.
        req_valid = '1;
        #1;
        checkOutput("rst_rsp_valid", PW'(rsp_valid), '0);
        checkOutput("rst_req_ready", PW'(req_ready), '0);
        checkOutput("rst_busy", PW'(busy), '0);
        checkOutput("rst_product", rsp_product, '0);
        checkOutput("rst_id", PW'(rsp_id), '0);
        req_valid = '0;
        doReset();

        // Single request from requester 2, full-rate consumer.
        setReq(2, 1'b1, 7, 6);
        rsp_ready = 1'b1;
        tick();
        checkOutput("t1_fired", PW'(fired_mask), PW'(4'b0100));
        req_valid = '0;
        tick();
        checkOutput("t1_rsp_valid", PW'(rsp_valid), 1);
        checkOutput("t1_rsp_id", PW'(rsp_id), 2);
        checkOutput("t1_product", rsp_product, 42);
        tick();

        // All requesters busy, rotating grants from pointer 0.
        doReset();
        applyStimulus(12, 100, 100, '1);

        // Backpressure: fill, stall, then release.
        applyStimulus(2, 100, 0, '1);
        rsp_ready = 1'b0;
        #1;
        checkOutput("bp_req_ready", PW'(req_ready), '0);
        checkOutput("bp_busy", PW'(busy), 1);
        applyStimulus(3, 100, 0, '1);
        applyStimulus(4, 0, 100, '1);
        drainPipe();

        // Extreme operands.
        setReq(0, 1'b1, '1, '1);
        rsp_ready = 1'b1;
        tick();
        checkOutput("ext_fired0", PW'(fired_mask[0]), 1);
        setReq(0, 1'b1, '0, 32'hDEADBEEF);
        tick();
        req_valid = '0;
        checkOutput("ext_max", rsp_product, 64'hFFFFFFFE00000001);
        tick();
        checkOutput("ext_zero_valid", PW'(rsp_valid), 1);
        checkOutput("ext_zero", rsp_product, '0);
        drainPipe();

        // Requester 1 streams while requester 3 pulses.
        rsp_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            setReq(3, 1'b1, randA(), randX());
            w = 0;
            do begin
                if (!req_valid[1] || fired_mask[1]) setReq(1, 1'b1, randA(), randX());
                tick();
                w++;
            end while (!fired_mask[3] && w < 6);
            checkOutput("req3_wait", PW'(w <= 2), 1);
            req_valid[3] = 1'b0;
            for (int c = 0; c < 2; c++) begin
                if (fired_mask[1]) setReq(1, 1'b1, randA(), randX());
                tick();
                checkOutput("req1_served", PW'(fired_mask[1]), 1);
            end
        end
        req_valid[1] = req_valid[1] && !fired_mask[1];
        drainPipe();

        // Random traffic with random backpressure.
        applyStimulus(300, 60, 75, '1);
        drainPipe();

        // Reset while both stages hold work.
        applyStimulus(2, 100, 0, '1);
        req_valid = '1;
        #1;
        model_on = 1'b0;
        rst      = 1'b1;
        #1;
        checkOutput("mid_rst_rsp_valid", PW'(rsp_valid), '0);
        checkOutput("mid_rst_busy", PW'(busy), '0);
        checkOutput("mid_rst_req_ready", PW'(req_ready), '0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        req_valid  = '0;
        sb.delete();
        model_ptr  = 0;
        fired_mask = '0;
        model_on   = 1'b1;
        applyStimulus(3, 0, 100, '1);
        applyStimulus(6, 100, 100, '1);
        drainPipe();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] timeout");
    end

endmodule
